nn_dma_host: RTL and testbench
==============================

# nn_dma_host

Host-side buffer and sequencer sitting at the far end of the `nn` accelerator's configuration and DMA ports. It programs the four 16-bit configuration registers, then serves DMA reads from a 1024×16 buffer memory. It captures accelerator DMA writes into the same memory and raises `o_done` after the expected number of result words has arrived. Outside a run, a simple host port preloads inputs and weights and reads results back.

## Interface
- `DATA_WIDTH`, 16, DMA/host word width
- `DMA_ADDR_WIDTH`, 10, buffer address width (depth 2^10)
- `CFG_WORDS`, 4, config words issued per start (matches 2-bit cfg address)
- `i_clk` input 1: sole clock, rising edge
- `i_rst` input 1: synchronous, active-high reset
- `i_host_wr_en` input 1: host buffer write strobe
- `i_host_addr` input DMA_ADDR_WIDTH: host read/write address
- `i_host_wr_data` input DATA_WIDTH: host write data
- `i_host_rd_en` input 1: host read strobe
- `o_host_rd_data` output DATA_WIDTH: host read data
- `o_host_rd_valid` output 1: host read data valid
- `i_start` input 1: single-cycle run request
- `i_cfg_data` input 64: config words; word k = bits [16k+15:16k]
- `i_out_words` input DMA_ADDR_WIDTH+1: accelerator writes expected per run
- `o_cfg` output 16: to accelerator `i_cfg`
- `o_cfg_addr` output 2: to `i_cfg_addr`
- `o_cfg_wr_en` output 1: to `i_cfg_wr_en`
- `i_dma_rd_addr` input DMA_ADDR_WIDTH: from accelerator `o_dma_rd_addr`
- `o_dma_rd_data` output DATA_WIDTH: to accelerator `i_dma_rd_data`
- `i_dma_wr_en` input 1, `i_dma_wr_addr` input DMA_ADDR_WIDTH, `i_dma_wr_data` input DATA_WIDTH: from accelerator write port
- `o_busy` output 1: CFG or RUN state
- `o_done` output 1: DONE state

## Operation
- **Memory.** One write port and two registered read ports (DMA and host).
- **Write-port ownership.** The host owns the write port in IDLE/DONE; the accelerator owns it in RUN. In CFG nothing writes.
- **DMA read port.** Always active: `o_dma_rd_data` = mem[`i_dma_rd_addr` sampled last cycle], in every state.
- **FSM states:** IDLE, CFG, RUN, DONE.
  - IDLE/DONE + `i_start` → CFG. Latch `i_cfg_data` and `i_out_words`, clear cfg counter and write counter, deassert `o_done`.
  - CFG: `o_cfg_wr_en`=1, `o_cfg_addr`=cnt, `o_cfg`=word[cnt], for cnt 0..3 (one word per cycle). After cnt=3 → RUN, or → DONE if latched out_words = 0.
  - RUN: each `i_dma_wr_en` writes mem[`i_dma_wr_addr`] and increments the write counter. When the incremented count equals out_words → DONE.
  - DONE: holds until `i_start` (restart) or reset.
- **Ignored events.** `i_start` is ignored in CFG/RUN. Host writes and reads are ignored in CFG/RUN; no `o_host_rd_valid` is produced. DMA writes outside RUN are ignored: not stored, not counted.
- **Host read.** In IDLE/DONE, `i_host_rd_en` produces `o_host_rd_data` = mem[`i_host_addr`] with `o_host_rd_valid`=1 on the next cycle. Otherwise `o_host_rd_valid`=0.
- **Read-during-write (same address, same cycle)** returns old data on both read ports.
- **Write counter** is DMA_ADDR_WIDTH+1 bits and cannot overflow before DONE. Writes to the same address count each time.

## Timing
- **Reset values:** state IDLE; `o_cfg`=0, `o_cfg_addr`=0, `o_cfg_wr_en`=0, `o_busy`=0, `o_done`=0, `o_host_rd_valid`=0, `o_host_rd_data`=0, `o_dma_rd_data`=0. Memory contents are not cleared.
- **Reset mid-run** returns to IDLE on the next edge. Counters clear; an in-flight cfg sequence is abandoned (no further `o_cfg_wr_en`).
- **Start/config sequence:** `i_start` sampled at edge t → `o_cfg_wr_en` high cycles t+1..t+4, addr 0,1,2,3; `o_busy` high from t+1. RUN from t+5.
- **Completion:** N-th DMA write sampled at edge r → `o_done`=1 and `o_busy`=0 from r+1. The written data is readable by the host at r+1.
- **Zero-word run:** out_words = 0 → DONE at t+5.
- **Latency:** all outputs are registered. DMA and host read latency is 1 cycle.

## Test plan
- **Host preload/readback:** reset, host writes 0xA5A5→addr 3 and 0x1234→addr 1023, reads both → valid one cycle after each `i_host_rd_en`, data matches; `o_busy`=0.
- **Config sequence:** `i_cfg_data`=0x4444_3333_2222_1111, `i_start` → four cycles of `o_cfg_wr_en` with (addr, data) = (0,0x1111),(1,0x2222),(2,0x3333),(3,0x4444); RUN entered next cycle.
- **Full run:** out_words=3; drive DMA reads of addr 3 → `o_dma_rd_data`=0xA5A5 one cycle later. Three DMA writes to addrs 10,11,12 → `o_done` rises the cycle after the third write; host readback returns the written values.
- **Ignored traffic:** host write during RUN and DMA write during IDLE → memory unchanged, write count unchanged. `i_start` during RUN → no new cfg burst.
- **Boundary cases:** out_words=0 → `o_done` at t+5. Simultaneous DMA write and DMA read to the same address → old data returned.
- **Reset mid-run:** `i_rst` at cycle 2 of CFG → `o_cfg_wr_en` low next cycle, state IDLE, preloaded memory intact on readback.

Source files
------------

// File: rtl/nn_dma_host.sv
// Host-side buffer and sequencer for the nn accelerator.
// Issues the config words, serves DMA reads and captures DMA result writes.
module nn_dma_host #(
    parameter int DATA_WIDTH     = 16,
    parameter int DMA_ADDR_WIDTH = 10,
    parameter int CFG_WORDS      = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_host_wr_en,
    input  logic [DMA_ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0]     i_host_wr_data,
    input  logic                      i_host_rd_en,
    output logic [DATA_WIDTH-1:0]     o_host_rd_data,
    output logic                      o_host_rd_valid,
    input  logic                      i_start,
    input  logic [DATA_WIDTH*CFG_WORDS-1:0] i_cfg_data,
    input  logic [DMA_ADDR_WIDTH:0]   i_out_words,
    output logic [DATA_WIDTH-1:0]     o_cfg,
    output logic [1:0]                o_cfg_addr,
    output logic                      o_cfg_wr_en,
    input  logic [DMA_ADDR_WIDTH-1:0] i_dma_rd_addr,
    output logic [DATA_WIDTH-1:0]     o_dma_rd_data,
    input  logic                      i_dma_wr_en,
    input  logic [DMA_ADDR_WIDTH-1:0] i_dma_wr_addr,
    input  logic [DATA_WIDTH-1:0]     i_dma_wr_data,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int DEPTH    = 1 << DMA_ADDR_WIDTH;
    localparam int CFG_BITS = DATA_WIDTH * CFG_WORDS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CFG,
        S_RUN,
        S_DONE
    } state_t;

    state_t                    state, state_n;
    logic [1:0]                cnt, cnt_n;
    logic [DMA_ADDR_WIDTH:0]   wr_cnt, wr_cnt_n;
    logic [DMA_ADDR_WIDTH:0]   out_words, out_words_n;
    logic [CFG_BITS-1:0]       cfg_q, cfg_n;

    logic                      host_own;
    logic                      mem_we;
    logic [DMA_ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [DATA_WIDTH-1:0]     mem [DEPTH];

    assign host_own = (state == S_IDLE) || (state == S_DONE);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        wr_cnt_n    = wr_cnt;
        out_words_n = out_words;
        cfg_n       = cfg_q;
        case (state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_n     = S_CFG;
                    cnt_n       = 2'd0;
                    wr_cnt_n    = '0;
                    cfg_n       = i_cfg_data;
                    out_words_n = i_out_words;
                end
            end
            S_CFG: begin
                if (cnt == 2'(CFG_WORDS - 1)) begin
                    state_n = (out_words == '0) ? S_DONE : S_RUN;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            S_RUN: begin
                if (i_dma_wr_en) begin
                    wr_cnt_n = wr_cnt + 1'b1;
                    if (wr_cnt_n == out_words) state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            cnt         <= 2'd0;
            wr_cnt      <= '0;
            out_words   <= '0;
            cfg_q       <= '0;
            o_cfg       <= '0;
            o_cfg_addr  <= 2'd0;
            o_cfg_wr_en <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            wr_cnt      <= wr_cnt_n;
            out_words   <= out_words_n;
            cfg_q       <= cfg_n;
            o_cfg_wr_en <= (state_n == S_CFG);
            o_cfg_addr  <= (state_n == S_CFG) ? cnt_n : 2'd0;
            o_cfg       <= (state_n == S_CFG) ?
                           cfg_n[cnt_n*DATA_WIDTH +: DATA_WIDTH] : '0;
            o_busy      <= (state_n == S_CFG) || (state_n == S_RUN);
            o_done      <= (state_n == S_DONE);
        end
    end

    always_comb begin
        mem_we  = 1'b0;
        wr_addr = i_host_addr;
        wr_data = i_host_wr_data;
        if (state == S_RUN) begin
            mem_we  = i_dma_wr_en & ~i_rst;
            wr_addr = i_dma_wr_addr;
            wr_data = i_dma_wr_data;
        end else if (host_own) begin
            mem_we = i_host_wr_en & ~i_rst;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dma_rd_data <= '0;
        end else begin
            o_dma_rd_data <= mem[i_dma_rd_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_host_rd_data  <= '0;
            o_host_rd_valid <= 1'b0;
        end else begin
            o_host_rd_valid <= host_own && i_host_rd_en;
            if (host_own && i_host_rd_en) begin
                o_host_rd_data <= mem[i_host_addr];
            end
        end
    end

endmodule

// File: tb/tb_nn_dma_host.sv
// Randomized self-checking bench for nn_dma_host.
// A plain array models the buffer; run behaviour follows the documented rules.
module tb_nn_dma_host;

    logic        clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_host_wr_en = 1'b0;
    logic [9:0]  i_host_addr = '0;
    logic [15:0] i_host_wr_data = '0;
    logic        i_host_rd_en = 1'b0;
    logic [15:0] o_host_rd_data;
    logic        o_host_rd_valid;
    logic        i_start = 1'b0;
    logic [63:0] i_cfg_data = '0;
    logic [10:0] i_out_words = '0;
    logic [15:0] o_cfg;
    logic [1:0]  o_cfg_addr;
    logic        o_cfg_wr_en;
    logic [9:0]  i_dma_rd_addr = '0;
    logic [15:0] o_dma_rd_data;
    logic        i_dma_wr_en = 1'b0;
    logic [9:0]  i_dma_wr_addr = '0;
    logic [15:0] i_dma_wr_data = '0;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;
    logic [15:0] mm [1024];

    always #5 clk = ~clk;

    nn_dma_host dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .i_host_wr_en(i_host_wr_en),
        .i_host_addr(i_host_addr),
        .i_host_wr_data(i_host_wr_data),
        .i_host_rd_en(i_host_rd_en),
        .o_host_rd_data(o_host_rd_data),
        .o_host_rd_valid(o_host_rd_valid),
        .i_start(i_start),
        .i_cfg_data(i_cfg_data),
        .i_out_words(i_out_words),
        .o_cfg(o_cfg),
        .o_cfg_addr(o_cfg_addr),
        .o_cfg_wr_en(o_cfg_wr_en),
        .i_dma_rd_addr(i_dma_rd_addr),
        .o_dma_rd_data(o_dma_rd_data),
        .i_dma_wr_en(i_dma_wr_en),
        .i_dma_wr_addr(i_dma_wr_addr),
        .i_dma_wr_data(i_dma_wr_data),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input logic [15:0] d);
        i_host_wr_en   = 1'b1;
        i_host_addr    = 10'(a);
        i_host_wr_data = d;
        tick();
        i_host_wr_en   = 1'b0;
    endtask

    task automatic host_read(input int a, output logic [15:0] d,
                             output logic v);
        i_host_rd_en = 1'b1;
        i_host_addr  = 10'(a);
        tick();
        d = o_host_rd_data;
        v = o_host_rd_valid;
        i_host_rd_en = 1'b0;
    endtask

    task automatic dma_write(input int a, input logic [15:0] d);
        i_dma_wr_en   = 1'b1;
        i_dma_wr_addr = 10'(a);
        i_dma_wr_data = d;
        tick();
        i_dma_wr_en   = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({o_busy, o_done, o_cfg_wr_en, o_host_rd_valid} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000",
                     {o_busy, o_done, o_cfg_wr_en, o_host_rd_valid});
        end
        checks++;
        if ({o_cfg, o_cfg_addr} !== 18'h0) begin
            errors++;
            $display("FAIL reset_cfg got %h/%0d want 0/0", o_cfg, o_cfg_addr);
        end
        checks++;
        if ({o_host_rd_data, o_dma_rd_data} !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd got %h/%h want 0/0",
                     o_host_rd_data, o_dma_rd_data);
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_host;
        logic [15:0] d;
        logic        v;
        int          a;
        for (int i = 0; i < 64; i++) begin
            d = 16'($urandom);
            host_write(i, d);
            mm[i] = d;
        end
        host_write(3, 16'hA5A5);
        mm[3] = 16'hA5A5;
        host_write(1023, 16'h1234);
        mm[1023] = 16'h1234;
        for (int i = 0; i < 8; i++) begin
            a = (i == 0) ? 3 : (i == 1) ? 1023 : int'($urandom_range(0, 63));
            host_read(a, d, v);
            checks++;
            if (v !== 1'b1 || d !== mm[a]) begin
                errors++;
                $display("FAIL host_rd[%0d] got v=%b %h want v=1 %h",
                         a, v, d, mm[a]);
            end
        end
        tick();
        checks++;
        if (o_host_rd_valid !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL host_idle got v=%b busy=%b want 0 0",
                     o_host_rd_valid, o_busy);
        end
        // same-cycle host write and read of one address returns old data
        a = int'($urandom_range(0, 63));
        i_host_wr_en   = 1'b1;
        i_host_rd_en   = 1'b1;
        i_host_addr    = 10'(a);
        i_host_wr_data = ~mm[a];
        tick();
        i_host_wr_en = 1'b0;
        i_host_rd_en = 1'b0;
        checks++;
        if (o_host_rd_data !== mm[a]) begin
            errors++;
            $display("FAIL host_rdw got %h want %h", o_host_rd_data, mm[a]);
        end
        mm[a] = ~mm[a];
        host_read(a, d, v);
        checks++;
        if (d !== mm[a]) begin
            errors++;
            $display("FAIL host_rdw_new got %h want %h", d, mm[a]);
        end
    endtask

    task automatic test_config(input logic [63:0] cfg, input int ow);
        logic [15:0] w;
        i_cfg_data  = cfg;
        i_out_words = 11'(ow);
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
        i_cfg_data  = {$urandom, $urandom};
        i_out_words = 11'($urandom);
        for (int k = 0; k < 4; k++) begin
            w = cfg[16*k +: 16];
            checks++;
            if ({o_cfg_wr_en, o_cfg_addr, o_cfg, o_busy, o_done} !==
                {1'b1, 2'(k), w, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL cfg_word%0d got en=%b a=%0d d=%h b=%b dn=%b want 1 %0d %h 1 0",
                         k, o_cfg_wr_en, o_cfg_addr, o_cfg, o_busy, o_done, k, w);
            end
            tick();
        end
        checks++;
        if ({o_cfg_wr_en, o_busy, o_done} !==
            {1'b0, (ow != 0), (ow == 0)}) begin
            errors++;
            $display("FAIL cfg_end ow=%0d got en=%b busy=%b done=%b",
                     ow, o_cfg_wr_en, o_busy, o_done);
        end
    endtask

    task automatic test_run(input bit fixed, input int ow);
        logic [15:0] d, exp_rd;
        logic        v;
        int          ra, wa;
        int          wlist[$];
        test_config(fixed ? 64'h4444_3333_2222_1111 : {$urandom, $urandom}, ow);
        for (int i = 0; i < ow; i++) begin
            ra = fixed ? 3 : int'($urandom_range(0, 63));
            wa = fixed ? 10 + i : int'($urandom_range(4, 20));
            d  = 16'($urandom);
            exp_rd = mm[ra];
            i_dma_rd_addr = 10'(ra);
            dma_write(wa, d);
            mm[wa] = d;
            wlist.push_back(wa);
            checks++;
            if (o_dma_rd_data !== exp_rd) begin
                errors++;
                $display("FAIL dma_rd[%0d] got %h want %h",
                         ra, o_dma_rd_data, exp_rd);
            end
            checks++;
            if ({o_done, o_busy} !== {(i == ow - 1), (i != ow - 1)}) begin
                errors++;
                $display("FAIL run_wr%0d/%0d got done=%b busy=%b",
                         i, ow, o_done, o_busy);
            end
        end
        foreach (wlist[j]) begin
            host_read(wlist[j], d, v);
            checks++;
            if (v !== 1'b1 || d !== mm[wlist[j]]) begin
                errors++;
                $display("FAIL run_readback[%0d] got v=%b %h want %h",
                         wlist[j], v, d, mm[wlist[j]]);
            end
        end
    endtask

    task automatic test_ignored;
        logic [15:0] d;
        logic        v;
        bit          saw;
        dma_write(5, ~mm[5]);
        host_read(5, d, v);
        checks++;
        if (d !== mm[5]) begin
            errors++;
            $display("FAIL dma_wr_outside_run got %h want %h", d, mm[5]);
        end
        test_config({$urandom, $urandom}, 2);
        host_write(6, ~mm[6]);
        host_read(6, d, v);
        checks++;
        if (v !== 1'b0) begin
            errors++;
            $display("FAIL host_rd_in_run got valid=%b want 0", v);
        end
        saw = 1'b0;
        i_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            saw |= o_cfg_wr_en;
        end
        i_start = 1'b0;
        checks++;
        if (saw !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_in_run got cfg_en_seen=%b busy=%b want 0 1",
                     saw, o_busy);
        end
        d = 16'($urandom);
        dma_write(7, d);
        mm[7] = d;
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL early_done got %b want 0", o_done);
        end
        d = 16'($urandom);
        dma_write(8, d);
        mm[8] = d;
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL second_done got %b want 1", o_done);
        end
        host_read(6, d, v);
        checks++;
        if (d !== mm[6]) begin
            errors++;
            $display("FAIL host_wr_in_run got %h want %h", d, mm[6]);
        end
    endtask

    task automatic test_zero;
        logic [15:0] d;
        logic        v;
        test_config({$urandom, $urandom}, 0);
        tick();
        host_read(1023, d, v);
        checks++;
        if (o_done !== 1'b1 || v !== 1'b1 || d !== mm[1023]) begin
            errors++;
            $display("FAIL zero_hold got done=%b v=%b %h want 1 1 %h",
                     o_done, v, d, mm[1023]);
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] d;
        logic        v;
        bit          saw;
        i_cfg_data  = {$urandom, $urandom};
        i_out_words = 11'd5;
        i_start     = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++;
        if ({o_cfg_wr_en, o_busy, o_done} !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset got en=%b busy=%b done=%b want 000",
                     o_cfg_wr_en, o_busy, o_done);
        end
        saw = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            saw |= o_cfg_wr_en;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_cfg got cfg_en_seen=%b want 0", saw);
        end
        host_read(3, d, v);
        checks++;
        if (v !== 1'b1 || d !== mm[3]) begin
            errors++;
            $display("FAIL mid_reset_mem got v=%b %h want 1 %h", v, d, mm[3]);
        end
    endtask

    task automatic test_back_to_back;
        for (int r = 0; r < 5; r++) begin
            test_run(1'b0, int'($urandom_range(1, 6)));
        end
    endtask

    initial begin
        test_reset();
        test_host();
        test_run(1'b1, 3);
        test_ignored();
        test_zero();
        test_run(1'b0, 1);
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
